lbus_responder: RTL
===================

Name: lbus_responder

Overview:
Main-FPGA end of the SAKURA-G local bus. The control FPGA's cipher_if acts as initiator; this block is the responder.
- Buffers incoming command bytes (lbus_wd/lbus_we) in an RX FIFO.
- Decodes read/write commands into a 16-bit register-bus access for the cipher core.
- Returns read data bytes through a TX FIFO drained by lbus_re.

Parameters:
FIFO_DEPTH, 16, entries in each of the RX and TX byte FIFOs; must be a power of 2 and at least 4.
CMD_RD, 8'h00, opcode for a register read.
CMD_WR, 8'h01, opcode for a register write.

Ports:
CLK  in  1  local bus clock (lbus_clk domain); one clock for the whole block.
RSTn  in  1  asynchronous active-low reset.
lbus_wd  in  8  write data from the control FPGA.
lbus_we  in  1  write enable; byte accepted when lbus_we=1 and lbus_ful=0.
lbus_ful  out  1  RX FIFO full.
lbus_rd  out  8  TX FIFO head byte (first-word fall-through).
lbus_re  in  1  read enable; pops when lbus_re=1 and lbus_emp=0.
lbus_emp  out  1  TX FIFO empty.
lbus_rdy  out  1  responder ready.
blk_addr  out  16  register address.
blk_wdata  out  16  register write data.
blk_we  out  1  one-cycle register write strobe.
blk_re  out  1  one-cycle register read strobe.
blk_rdata  in  16  register read data, valid 1 cycle after blk_re.
bad_cmd_cnt  out  8  count of discarded opcodes (see Optional Feature).

Behaviour:
- Reset values:
  - FIFOs empty: lbus_ful=0, lbus_emp=1, lbus_rd=8'h00.
  - lbus_rdy=0; it rises on the first CLK edge after RSTn deasserts and stays at 1.
  - blk_addr=0, blk_wdata=0, blk_we=0, blk_re=0, bad_cmd_cnt=0.
  - FSM in IDLE.
- Reset asserted mid-command: the partial command is lost, both FIFOs are flushed, no strobe is issued.
- RX FIFO:
  - A write while full is ignored and the FIFO is unchanged.
  - lbus_ful is registered and asserts in the same cycle the last free slot fills.
  - The FSM pops one byte per cycle when the FIFO is non-empty and the current state consumes a byte.
- Command framing, bytes in order (big-endian):
  - Read: CMD_RD, ADDR[15:8], ADDR[7:0].
  - Write: CMD_WR, ADDR[15:8], ADDR[7:0], DATA[15:8], DATA[7:0].
- FSM states: IDLE, AH, AL, DH, DL, WR, RCHK, RD, RCAP.
  - IDLE: pop opcode. CMD_RD or CMD_WR goes to AH and latches the opcode. Any other value is dropped; stay in IDLE and increment bad_cmd_cnt (feature on).
  - AH/AL: pop the address bytes into blk_addr. After AL, go to DH if the opcode is write, otherwise RCHK.
  - DH/DL: pop the data bytes into blk_wdata, then go to WR.
  - WR: blk_we=1 for exactly one cycle, then IDLE. Write latency from the last byte popped to the strobe is 1 cycle.
  - RCHK: wait until the TX FIFO has at least 2 free slots, then go to RD. Reads never overflow the TX FIFO.
  - RD: blk_re=1 for one cycle, go to RCAP.
  - RCAP: capture blk_rdata and push the high byte into the TX FIFO this cycle and the low byte the next cycle, then IDLE. The low byte comes from a holding register.
- States AH through DL wait in place while the RX FIFO is empty; there is no timeout.
- TX FIFO:
  - lbus_rd shows the head byte combinationally from storage.
  - A pop and a push in the same cycle are legal and keep the count unchanged.
  - lbus_re while empty is ignored.
- blk_addr and blk_wdata hold their value until the next command overwrites them.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full means MSBs differ and the rest are equal.

Optional Feature:
LBUS_RESP_BADCMD_CNT_EN.
- Defined: bad_cmd_cnt is an 8-bit counter of dropped opcodes that saturates at 8'hFF and clears only on reset.
- Undefined: bad_cmd_cnt is tied to 8'h00, no counter logic exists, and invalid opcodes are still dropped silently.

Decomposition:
- Package lbus_pkg holds:
  - state enum encoding (4-bit);
  - CMD_RD and CMD_WR default constants;
  - byte and word width constants (8, 16).
- One sub-module, lbus_byte_fifo: synchronous FIFO with async active-low reset, parameter DEPTH, first-word fall-through, full/empty flags and a free-count output. It is instantiated twice (RX and TX).

Test Plan:
- Write: bytes 01 12 34 AB CD pushed back-to-back.
  - blk_we pulses once, with blk_addr=16'h1234 and blk_wdata=16'hABCD.
  - blk_we rises 1 cycle after the last pop; no TX push occurs.
- Read: bytes 00 00 10 with blk_rdata=16'h5A3C.
  - blk_re pulses once with blk_addr=16'h0010.
  - lbus_emp falls, then lbus_rd=5A; after lbus_re, lbus_rd=3C; after the next lbus_re, lbus_emp=1.
- Bad opcode: bytes 7F followed by a valid write.
  - 7F is dropped with no strobe; bad_cmd_cnt=1 (feature on) or 0 (feature off).
  - The following write executes correctly.
- Full/backpressure: 17 bytes written with FIFO_DEPTH=16 while the FSM is stalled (TX FIFO full, read pending).
  - lbus_ful=1 after the 16th byte; the 17th byte is not stored.
  - The read completes after 2 TX bytes are drained.
- Reset mid-command: assert RSTn=0 after 00 12 only.
  - All outputs return to their reset values, lbus_emp=1, and no blk_re is issued.
  - A subsequent write 01 00 01 00 02 gives blk_addr=1 and blk_wdata=2.
- Simultaneous TX push/pop: continuous lbus_re during back-to-back reads.
  - The output byte order is preserved and lbus_emp never glitches low with stale data.

Source files
------------

// File: rtl/lbus_pkg.sv
// rtl/lbus_pkg.sv - shared widths, default opcodes and FSM encoding for the local bus responder
package lbus_pkg;

  localparam int LBUS_BYTE_W = 8;
  localparam int LBUS_WORD_W = 16;

  localparam logic [LBUS_BYTE_W-1:0] LBUS_CMD_RD = 8'h00;
  localparam logic [LBUS_BYTE_W-1:0] LBUS_CMD_WR = 8'h01;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_AH   = 4'd1,
    ST_AL   = 4'd2,
    ST_DH   = 4'd3,
    ST_DL   = 4'd4,
    ST_WR   = 4'd5,
    ST_RCHK = 4'd6,
    ST_RD   = 4'd7,
    ST_RCAP = 4'd8
  } lbus_state_e;

endpackage

// File: rtl/lbus_byte_fifo.sv
// rtl/lbus_byte_fifo.sv - first-word fall-through byte FIFO with full/empty flags and free count
module lbus_byte_fifo
  import lbus_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [LBUS_BYTE_W-1:0] wdata_i,
  input  logic                   pop_i,
  output logic [LBUS_BYTE_W-1:0] rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] free_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]            wr_ptr_q;
  logic [AW:0]            rd_ptr_q;
  logic [AW:0]            count;
  logic [LBUS_BYTE_W-1:0] mem_q [DEPTH];
  logic                   push_ok;
  logic                   pop_ok;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign full_o  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign free_o  = (AW + 1)'(DEPTH) - count;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/lbus_responder.sv
// rtl/lbus_responder.sv - SAKURA-G local bus responder decoding byte commands into register accesses
// Define LBUS_RESP_BADCMD_CNT_EN to count dropped opcodes on bad_cmd_cnt.
module lbus_responder
  import lbus_pkg::*;
#(
  parameter int                     FIFO_DEPTH = 16,
  parameter logic [LBUS_BYTE_W-1:0] CMD_RD     = LBUS_CMD_RD,
  parameter logic [LBUS_BYTE_W-1:0] CMD_WR     = LBUS_CMD_WR
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic [LBUS_BYTE_W-1:0] lbus_wd,
  input  logic                   lbus_we,
  output logic                   lbus_ful,
  output logic [LBUS_BYTE_W-1:0] lbus_rd,
  input  logic                   lbus_re,
  output logic                   lbus_emp,
  output logic                   lbus_rdy,
  output logic [LBUS_WORD_W-1:0] blk_addr,
  output logic [LBUS_WORD_W-1:0] blk_wdata,
  output logic                   blk_we,
  output logic                   blk_re,
  input  logic [LBUS_WORD_W-1:0] blk_rdata,
  output logic [LBUS_BYTE_W-1:0] bad_cmd_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  lbus_state_e            state_q, state_d;
  logic                   is_wr_q, is_wr_d;
  logic [LBUS_WORD_W-1:0] addr_q, addr_d;
  logic [LBUS_WORD_W-1:0] wdata_q, wdata_d;
  logic [LBUS_BYTE_W-1:0] lo_q, lo_d;
  logic                   lo_pend_q, lo_pend_d;
  logic                   rdy_q;
  logic                   bad_inc;

  logic [LBUS_BYTE_W-1:0] rx_rdata;
  logic                   rx_empty;
  logic                   rx_pop;
  logic [AW:0]            rx_free;
  logic                   tx_push;
  logic [LBUS_BYTE_W-1:0] tx_wdata;
  logic                   tx_full;
  logic [AW:0]            tx_free;
  logic                   unused_fifo;

  lbus_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (CLK),
    .rst_ni  (RSTn),
    .push_i  (lbus_we),
    .wdata_i (lbus_wd),
    .pop_i   (rx_pop),
    .rdata_o (rx_rdata),
    .full_o  (lbus_ful),
    .empty_o (rx_empty),
    .free_o  (rx_free)
  );

  lbus_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (CLK),
    .rst_ni  (RSTn),
    .push_i  (tx_push),
    .wdata_i (tx_wdata),
    .pop_i   (lbus_re),
    .rdata_o (lbus_rd),
    .full_o  (tx_full),
    .empty_o (lbus_emp),
    .free_o  (tx_free)
  );

  assign unused_fifo = ^{rx_free, tx_full};

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    lo_pend_d = 1'b0;
    rx_pop    = 1'b0;
    bad_inc   = 1'b0;
    // The low read byte always lands the cycle after RCAP, whatever state follows.
    tx_push   = lo_pend_q;
    tx_wdata  = lo_q;
    case (state_q)
      ST_IDLE: if (!rx_empty) begin
        rx_pop = 1'b1;
        if (rx_rdata == CMD_RD || rx_rdata == CMD_WR) begin
          is_wr_d = (rx_rdata == CMD_WR);
          state_d = ST_AH;
        end else begin
          bad_inc = 1'b1;
        end
      end
      ST_AH: if (!rx_empty) begin
        rx_pop        = 1'b1;
        addr_d[15:8]  = rx_rdata;
        state_d       = ST_AL;
      end
      ST_AL: if (!rx_empty) begin
        rx_pop       = 1'b1;
        addr_d[7:0]  = rx_rdata;
        state_d      = is_wr_q ? ST_DH : ST_RCHK;
      end
      ST_DH: if (!rx_empty) begin
        rx_pop        = 1'b1;
        wdata_d[15:8] = rx_rdata;
        state_d       = ST_DL;
      end
      ST_DL: if (!rx_empty) begin
        rx_pop       = 1'b1;
        wdata_d[7:0] = rx_rdata;
        state_d      = ST_WR;
      end
      ST_WR:   state_d = ST_IDLE;
      // Both response bytes are reserved up front so the TX push never meets a full FIFO.
      ST_RCHK: if (tx_free >= (AW + 1)'(2)) state_d = ST_RD;
      ST_RD:   state_d = ST_RCAP;
      ST_RCAP: begin
        tx_push   = 1'b1;
        tx_wdata  = blk_rdata[15:8];
        lo_d      = blk_rdata[7:0];
        lo_pend_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      lo_pend_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lo_q      <= lo_d;
      lo_pend_q <= lo_pend_d;
      rdy_q     <= 1'b1;
    end
  end

  assign blk_addr  = addr_q;
  assign blk_wdata = wdata_q;
  assign blk_we    = (state_q == ST_WR);
  assign blk_re    = (state_q == ST_RD);
  assign lbus_rdy  = rdy_q;

`ifdef LBUS_RESP_BADCMD_CNT_EN
  logic [LBUS_BYTE_W-1:0] bad_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      bad_q <= '0;
    end else if (bad_inc && bad_q != 8'hFF) begin
      bad_q <= bad_q + 8'd1;
    end
  end

  assign bad_cmd_cnt = bad_q;
`else
  logic unused_bad;

  assign unused_bad  = bad_inc;
  assign bad_cmd_cnt = 8'h00;
`endif

endmodule
